hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS datapath. It generates the `En`/`Clr` pairs consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable. It covers load-use stalls, taken-branch flushes, multiply/divide busy stalls and data-memory wait freezes. It tracks multi-cycle mult/div occupancy with an internal counter and keeps a saturating stall-cycle statistic.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_ctrl_md_busy_counter.sv | 23 ++
 rtl/hazard_ctrl.sv | 89 ++++++++
 tb/tb_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared defaults and the response encoding for the pipeline hazard controller.
package hazard_pkg;
  localparam int REG_W_DEF     = 5;
  localparam int MD_CYCLES_DEF = 32;
  localparam int STAT_W_DEF    = 16;

  // Active hazard response for the current cycle, highest priority last.
  typedef enum logic [2:0] {
    RSP_NONE,
    RSP_LOADUSE,
    RSP_HILO,
    RSP_FLUSH,
    RSP_FREEZE
  } resp_e;
endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Mult/div occupancy counter: loads MD_CYCLES-1 on an accepted start, then counts down to idle.
module md_busy_counter #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = $clog2(MD_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [CNT_W-1:0] count,
  output logic             busy
);
  assign busy = (count != '0);

  // A start while busy is illegal upstream; it is dropped so the running op keeps its slot.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (start && !busy)
      count <= CNT_W'(MD_CYCLES - 1);
    else if (busy)
      count <= count - CNT_W'(1);
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: stall, flush and freeze controls plus stall statistic.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter int MD_CYCLES = MD_CYCLES_DEF,
  parameter int STAT_W    = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic              ID_UseRs,
  input  logic              ID_UseRt,
  input  logic              ID_UseHiLo,
  input  logic [REG_W-1:0]  EX_Rd,
  input  logic              EX_WriteReg,
  input  logic              EX_MemToReg,
  input  logic              EX_MDStart,
  input  logic              Branch_Taken,
  input  logic              Mem_Wait,
  output logic              PC_En,
  output logic              IFID_En,
  output logic              IFID_Clr,
  output logic              IDEX_En,
  output logic              IDEX_Clr,
  output logic              EXMEM_En,
  output logic              EXMEM_Clr,
  output logic              MEMWB_En,
  output logic              MEMWB_Clr,
  output logic              MD_Busy,
  output logic [STAT_W-1:0] Stall_Cnt
);
  localparam int CNT_W = $clog2(MD_CYCLES);

  logic [CNT_W-1:0] md_count;
  logic             load_use, hilo_stall;
  resp_e            resp;

  // A frozen EX cannot launch, so the start only counts when memory is ready.
  md_busy_counter #(.MD_CYCLES(MD_CYCLES), .CNT_W(CNT_W)) u_md (
    .clk   (clk),
    .rst   (rst),
    .start (EX_MDStart & ~Mem_Wait),
    .count (md_count),
    .busy  (MD_Busy)
  );

  assign load_use = EX_MemToReg & EX_WriteReg & (EX_Rd != '0) &
                    ((ID_UseRs & (ID_Rs == EX_Rd)) | (ID_UseRt & (ID_Rt == EX_Rd)));
  assign hilo_stall = ID_UseHiLo & (md_count != '0);

  always_comb begin
    resp = RSP_NONE;
    if (Mem_Wait)          resp = RSP_FREEZE;
    else if (Branch_Taken) resp = RSP_FLUSH;
    else if (hilo_stall)   resp = RSP_HILO;
    else if (load_use)     resp = RSP_LOADUSE;
  end

  always_comb begin
    PC_En = 1'b1; IFID_En = 1'b1; IFID_Clr = 1'b0; IDEX_En = 1'b1; IDEX_Clr = 1'b0;
    EXMEM_En = 1'b1; EXMEM_Clr = 1'b0; MEMWB_En = 1'b1; MEMWB_Clr = 1'b0;
    case (resp)
      RSP_FREEZE: begin
        PC_En = 1'b0; IFID_En = 1'b0; IDEX_En = 1'b0; EXMEM_En = 1'b0; MEMWB_Clr = 1'b1;
      end
      RSP_FLUSH: begin
        IFID_Clr = 1'b1; IDEX_Clr = 1'b1;
      end
      RSP_HILO, RSP_LOADUSE: begin
        PC_En = 1'b0; IFID_En = 1'b0; IDEX_Clr = 1'b1;
      end
      default: ;
    endcase
    // Reset holds every stage empty regardless of hazard inputs.
    if (rst) begin
      PC_En = 1'b0; IFID_En = 1'b0; IDEX_En = 1'b0; EXMEM_En = 1'b0; MEMWB_En = 1'b0;
      IFID_Clr = 1'b1; IDEX_Clr = 1'b1; EXMEM_Clr = 1'b1; MEMWB_Clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      Stall_Cnt <= '0;
    else if (!PC_En && (Stall_Cnt != '1))
      Stall_Cnt <= Stall_Cnt + STAT_W'(1);
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed checks of hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int MDC   = 32;
  localparam int SW    = 10;
  localparam int SMAX  = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] ID_Rs, ID_Rt, EX_Rd;
  logic ID_UseRs, ID_UseRt, ID_UseHiLo, EX_WriteReg, EX_MemToReg, EX_MDStart;
  logic Branch_Taken, Mem_Wait;
  logic PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr, EXMEM_En, EXMEM_Clr, MEMWB_En, MEMWB_Clr;
  logic MD_Busy;
  logic [SW-1:0] Stall_Cnt;

  int tests = 0;
  int fails = 0;
  int m_md   = 0;  // cycles of mult/div occupancy still remaining
  int m_stat = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(REG_W), .MD_CYCLES(MDC), .STAT_W(SW)) dut (
    .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_UseHiLo(ID_UseHiLo), .EX_Rd(EX_Rd), .EX_WriteReg(EX_WriteReg), .EX_MemToReg(EX_MemToReg),
    .EX_MDStart(EX_MDStart), .Branch_Taken(Branch_Taken), .Mem_Wait(Mem_Wait),
    .PC_En(PC_En), .IFID_En(IFID_En), .IFID_Clr(IFID_Clr), .IDEX_En(IDEX_En), .IDEX_Clr(IDEX_Clr),
    .EXMEM_En(EXMEM_En), .EXMEM_Clr(EXMEM_Clr), .MEMWB_En(MEMWB_En), .MEMWB_Clr(MEMWB_Clr),
    .MD_Busy(MD_Busy), .Stall_Cnt(Stall_Cnt)
  );

  a_no_md_overlap: assert property (@(posedge clk) disable iff (rst) !(EX_MDStart && MD_Busy));

  // Vectors: {PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr, EXMEM_En, EXMEM_Clr, MEMWB_En, MEMWB_Clr}
  localparam logic [8:0] V_RST   = 9'b0_0_1_0_1_0_1_0_1;
  localparam logic [8:0] V_FRZ   = 9'b0_0_0_0_0_0_0_1_1;
  localparam logic [8:0] V_FLUSH = 9'b1_1_1_1_1_1_0_1_0;
  localparam logic [8:0] V_STALL = 9'b0_0_0_1_1_1_0_1_0;
  localparam logic [8:0] V_DEF   = 9'b1_1_0_1_0_1_0_1_0;

  function automatic logic [8:0] act();
    return {PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr, EXMEM_En, EXMEM_Clr, MEMWB_En, MEMWB_Clr};
  endfunction

  function automatic logic [8:0] exp_now();
    bit lu, hl;
    lu = EX_MemToReg && EX_WriteReg && (EX_Rd != 0) &&
         ((ID_UseRs && ID_Rs == EX_Rd) || (ID_UseRt && ID_Rt == EX_Rd));
    hl = ID_UseHiLo && (m_md != 0);
    if (rst)               return V_RST;
    else if (Mem_Wait)     return V_FRZ;
    else if (Branch_Taken) return V_FLUSH;
    else if (hl || lu)     return V_STALL;
    return V_DEF;
  endfunction

  // Advance one clock, updating the reference model from the inputs held across the edge.
  task automatic adv();
    logic [8:0] e;
    e = exp_now();
    @(posedge clk);
    if (rst) begin
      m_md = 0; m_stat = 0;
    end else begin
      if (EX_MDStart && !Mem_Wait && m_md == 0) m_md = MDC - 1;
      else if (m_md > 0) m_md = m_md - 1;
      if (!e[8] && m_stat < SMAX) m_stat = m_stat + 1;
    end
    #1;
  endtask

  task automatic idle();
    ID_Rs = '0; ID_Rt = '0; ID_UseRs = 0; ID_UseRt = 0; ID_UseHiLo = 0; EX_Rd = '0;
    EX_WriteReg = 0; EX_MemToReg = 0; EX_MDStart = 0; Branch_Taken = 0; Mem_Wait = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    adv(); adv();
    @(negedge clk);
    tests++; if (act() !== V_RST) begin fails++; $display("FAIL reset_ctrl got %b want %b", act(), V_RST); end
    tests++; if (Stall_Cnt !== '0) begin fails++; $display("FAIL reset_stat got %0d want 0", Stall_Cnt); end
    tests++; if (MD_Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", MD_Busy); end
    adv(); rst = 0;
    @(negedge clk);
    tests++; if (act() !== V_DEF) begin fails++; $display("FAIL post_reset_default got %b want %b", act(), V_DEF); end
    adv();
  endtask

  task automatic test_load_use();
    EX_Rd = 5; EX_WriteReg = 1; EX_MemToReg = 1; ID_Rs = 5; ID_UseRs = 1; ID_Rt = 2; ID_UseRt = 1;
    @(negedge clk);
    tests++; if (act() !== V_STALL) begin fails++; $display("FAIL load_use_stall got %b want %b", act(), V_STALL); end
    adv();
    EX_MemToReg = 0;  // the stalled add now sees a bubble in EX
    @(negedge clk);
    tests++; if (act() !== V_DEF) begin fails++; $display("FAIL load_use_release got %b want %b", act(), V_DEF); end
    adv();
    EX_Rd = 0; EX_MemToReg = 1; ID_Rs = 0; ID_Rt = 0;
    @(negedge clk);
    tests++; if (act() !== V_DEF) begin fails++; $display("FAIL load_r0_nostall got %b want %b", act(), V_DEF); end
    adv();
    EX_Rd = 9; ID_Rs = 1; ID_Rt = 9; ID_UseRt = 0;
    @(negedge clk);
    tests++; if (act() !== V_DEF) begin fails++; $display("FAIL load_rt_unused got %b want %b", act(), V_DEF); end
    adv(); idle();
  endtask

  task automatic test_hilo();
    int s0, nbusy, nstall, cyc;
    bit released;
    EX_MDStart = 1;
    @(negedge clk);
    tests++; if (MD_Busy !== 1'b0) begin fails++; $display("FAIL md_start_busy got %b want 0", MD_Busy); end
    s0 = int'(Stall_Cnt);
    adv();
    EX_MDStart = 0; ID_UseHiLo = 1;
    nbusy = 0; nstall = 0; released = 0;
    for (cyc = 0; cyc < 40 && !released; cyc++) begin
      @(negedge clk);
      tests++; if (act() !== exp_now()) begin fails++; $display("FAIL hilo_cycle%0d got %b want %b", cyc, act(), exp_now()); end
      if (MD_Busy) nbusy++;
      if (!PC_En) nstall++;
      if (!MD_Busy) released = 1;
      else adv();
    end
    tests++; if (!released) begin fails++; $display("FAIL hilo_timeout busy never fell within 40 cycles"); end
    tests++; if (nbusy != MDC - 1) begin fails++; $display("FAIL hilo_busy_cycles got %0d want %0d", nbusy, MDC - 1); end
    tests++; if (nstall != MDC - 1) begin fails++; $display("FAIL hilo_stall_cycles got %0d want %0d", nstall, MDC - 1); end
    tests++; if (int'(Stall_Cnt) != s0 + MDC - 1) begin fails++; $display("FAIL hilo_stat got %0d want %0d", Stall_Cnt, s0 + MDC - 1); end
    adv(); idle();
  endtask

  task automatic test_branch();
    EX_Rd = 7; EX_WriteReg = 1; EX_MemToReg = 1; ID_Rs = 7; ID_UseRs = 1; Branch_Taken = 1;
    @(negedge clk);
    tests++; if (act() !== V_FLUSH) begin fails++; $display("FAIL branch_over_loaduse got %b want %b", act(), V_FLUSH); end
    adv(); idle();
  endtask

  task automatic test_mem_wait();
    Branch_Taken = 1; Mem_Wait = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (act() !== V_FRZ) begin fails++; $display("FAIL mem_freeze%0d got %b want %b", i, act(), V_FRZ); end
      adv();
    end
    Mem_Wait = 0;
    @(negedge clk);
    tests++; if (act() !== V_FLUSH) begin fails++; $display("FAIL flush_after_freeze got %b want %b", act(), V_FLUSH); end
    adv(); idle();
  endtask

  task automatic test_reset_mid_md();
    EX_MDStart = 1; adv(); EX_MDStart = 0;
    for (int i = 0; i < 40 && m_md != 10; i++) adv();
    @(negedge clk);
    tests++; if (MD_Busy !== 1'b1) begin fails++; $display("FAIL mid_md_busy got %b want 1", MD_Busy); end
    rst = 1;
    @(negedge clk);
    tests++; if (act() !== V_RST) begin fails++; $display("FAIL mid_md_rst_ctrl got %b want %b", act(), V_RST); end
    adv();
    @(negedge clk);
    tests++; if (MD_Busy !== 1'b0) begin fails++; $display("FAIL mid_md_abort got %b want 0", MD_Busy); end
    tests++; if (Stall_Cnt !== '0) begin fails++; $display("FAIL mid_md_stat got %0d want 0", Stall_Cnt); end
    rst = 0; ID_UseHiLo = 1;
    @(negedge clk);
    tests++; if (act() !== V_DEF) begin fails++; $display("FAIL mid_md_after got %b want %b", act(), V_DEF); end
    adv(); idle();
  endtask

  task automatic test_saturate();
    EX_Rd = 3; EX_WriteReg = 1; EX_MemToReg = 1; ID_Rt = 3; ID_UseRt = 1;
    for (int i = 0; i < SMAX + 8; i++) adv();
    @(negedge clk);
    tests++; if (int'(Stall_Cnt) != SMAX) begin fails++; $display("FAIL stat_saturate got %0d want %0d", Stall_Cnt, SMAX); end
    adv(); adv();
    @(negedge clk);
    tests++; if (int'(Stall_Cnt) != SMAX) begin fails++; $display("FAIL stat_hold got %0d want %0d", Stall_Cnt, SMAX); end
    rst = 1; adv(); rst = 0; idle(); adv();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(99) < 2);
      ID_Rs        = REG_W'($urandom_range(3));
      ID_Rt        = REG_W'($urandom_range(3));
      EX_Rd        = REG_W'($urandom_range(3));
      ID_UseRs     = $urandom_range(1);
      ID_UseRt     = $urandom_range(1);
      ID_UseHiLo   = ($urandom_range(99) < 30);
      EX_WriteReg  = ($urandom_range(99) < 70);
      EX_MemToReg  = ($urandom_range(99) < 50);
      Branch_Taken = ($urandom_range(99) < 15);
      Mem_Wait     = ($urandom_range(99) < 15);
      EX_MDStart   = (m_md == 0) && ($urandom_range(99) < 10);
      @(negedge clk);
      tests++; if (act() !== exp_now()) begin fails++; $display("FAIL rand%0d_ctrl got %b want %b", i, act(), exp_now()); end
      tests++; if (MD_Busy !== (m_md != 0)) begin fails++; $display("FAIL rand%0d_busy got %b want %b", i, MD_Busy, m_md != 0); end
      tests++; if (int'(Stall_Cnt) != m_stat) begin fails++; $display("FAIL rand%0d_stat got %0d want %0d", i, Stall_Cnt, m_stat); end
      adv();
    end
    rst = 0; idle();
  endtask

  initial begin
    rst = 1; idle();
    #1;
    test_reset();
    test_load_use();
    test_hilo();
    test_branch();
    test_mem_wait();
    test_reset_mid_md();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
